// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with valid/ready handshakes on operands and result.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry_q;
    logic [CW-1:0]    bit_cnt;
    logic             last_bit;
    logic             ha0;
    logic             c0;
    logic             c1;
    logic             s_bit;
    logic             c_next;

    // Full-adder cell built from two cascaded half adders.
    assign ha0      = a_sh[0] ^ b_sh[0];
    assign c0       = a_sh[0] & b_sh[0];
    assign s_bit    = ha0 ^ carry_q;
    assign c1       = ha0 & carry_q;
    assign c_next   = c0 | c1;
    assign last_bit = (bit_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (in_valid) state_next = RUN;
            RUN:  if (last_bit) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operands shift out LSB first, sum bits enter from the MSB side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_q <= 1'b0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        bit_cnt <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    sum_sh  <= {s_bit, sum_sh[WIDTH-1:1]};
                    carry_q <= c_next;
                    bit_cnt <= bit_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_sh;
    assign carry     = carry_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic c_msb;

    // Carry into the MSB is the carry flop value while the last bit is processed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_msb <= 1'b0;
        end else if (state == RUN && last_bit) begin
            c_msb <= carry_q;
        end
    end

    assign overflow = (state == DONE) && (c_msb ^ carry_q);
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard testbench for serial_adder at WIDTH=4 using directed vectors.
// Overflow checks are included when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry;
    logic         busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic         overflow;
`endif

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Present operands until accepted; optionally record the expected result.
    task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic vc, input logic push,
                                 input logic [W-1:0] es, input logic ec, input logic eo);
        int n = 0;
        a        = va;
        b        = vb;
        cin      = vc;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 1);
        if (push) sbq.push_back('{sum: es, carry: ec, ovf: eo});
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic waitResult(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(name, 32'(cyc - acc_cyc), 4);
    endtask

    // Monitor: pops the scoreboard on every result handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected_result", 32'(sbq.size()), 1);
            end else begin
                e = sbq.pop_front();
                checkOutput("sum", 32'(sum), 32'(e.sum));
                checkOutput("carry", 32'(carry), 32'(e.carry));
`ifdef SERIAL_ADDER_OVF_EN
                checkOutput("overflow", 32'(overflow), 32'(e.ovf));
`endif
            end
        end
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        #12;
        checkOutput("reset_in_ready", 32'(in_ready), 1);
        checkOutput("reset_out_valid", 32'(out_valid), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_sum", 32'(sum), 0);
        checkOutput("reset_carry", 32'(carry), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] zero operands");
        applyStimulus(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        waitResult("latency_zero");
        @(posedge clk); #1;
        checkOutput("idle_after_ack", 32'(in_ready), 1);

        $display("[TB] carry chains");
        applyStimulus(4'hF, 4'h1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0);
        waitResult("latency_f_plus_1");
        @(posedge clk); #1;
        applyStimulus(4'hF, 4'hF, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0);
        waitResult("latency_all_ones");
        @(posedge clk); #1;

        $display("[TB] consumer stall");
        out_ready = 1'b0;
        applyStimulus(4'h5, 4'h3, 1'b1, 1'b1, 4'h9, 1'b0, 1'b1);
        waitResult("latency_stall");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("stall_out_valid", 32'(out_valid), 1);
            checkOutput("stall_sum", 32'(sum), 32'h9);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("stall_release_in_ready", 32'(in_ready), 1);
        checkOutput("stall_release_out_valid", 32'(out_valid), 0);

        $display("[TB] in_valid ignored while busy");
        applyStimulus(4'h2, 4'h2, 1'b0, 1'b1, 4'h4, 1'b0, 1'b0);
        a        = 4'h7;
        b        = 4'h7;
        cin      = 1'b1;
        in_valid = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin
            checkOutput("run_in_ready", 32'(in_ready), 0);
            @(posedge clk); #1;
            n++;
        end
        checkOutput("latency_busy", 32'(cyc - acc_cyc), 4);
        checkOutput("done_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        checkOutput("ack_edge_no_accept", 32'(busy), 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("still_idle", 32'(busy), 0);

        $display("[TB] reset mid-run");
        applyStimulus(4'h5, 4'h6, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", 32'(out_valid), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_sum", 32'(sum), 0);
        checkOutput("abort_carry", 32'(carry), 0);
        checkOutput("abort_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(4'h1, 4'h1, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
        waitResult("latency_after_reset");
        @(posedge clk); #1;

`ifdef SERIAL_ADDER_OVF_EN
        $display("[TB] signed overflow");
        applyStimulus(4'h7, 4'h1, 1'b0, 1'b1, 4'h8, 1'b0, 1'b1);
        waitResult("latency_ovf_pos");
        @(posedge clk); #1;
        applyStimulus(4'h8, 4'h8, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1);
        waitResult("latency_ovf_neg");
        @(posedge clk); #1;
        applyStimulus(4'h3, 4'h2, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
        waitResult("latency_no_ovf");
        @(posedge clk); #1;
        checkOutput("ovf_idle", 32'(overflow), 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(sbq.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
